// File: rtl/proto_field_decoder_if.sv
`default_nettype none
//==============================================================================
// Module   : proto_field_decoder_if
// Brief    : Byte stream in, field records and type-2 payload bytes out.
// Revision : 1.0
//==============================================================================
interface proto_field_decoder_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [28:0] out_field_id;
    logic [2:0]  out_wire_type;
    logic [63:0] out_value;
    logic        out_valid;
    logic        out_ready;
    logic        err;
    logic [2:0]  err_code;
    logic [7:0]  pay_data;
    logic        pay_valid;
    logic        pay_last;
    logic        pay_ready;

    // master is the decoder, slave is the surrounding logic
    modport master (
        input  in_data, in_valid, in_last, out_ready, pay_ready,
        output in_ready, out_field_id, out_wire_type, out_value, out_valid,
               err, err_code, pay_data, pay_valid, pay_last
    );

    modport slave (
        output in_data, in_valid, in_last, out_ready, pay_ready,
        input  in_ready, out_field_id, out_wire_type, out_value, out_valid,
               err, err_code, pay_data, pay_valid, pay_last
    );
endinterface
`default_nettype wire

// File: rtl/proto_field_decoder.sv
`default_nettype none
//==============================================================================
// Module   : proto_field_decoder
// Brief    : Byte-serial protobuf wire-format decoder, one record per field.
//            Option macro PROTO_LEN_PASSTHRU_EN forwards type-2 payload bytes.
// Revision : 1.0
//==============================================================================
module proto_field_decoder #(
    parameter int LEN_W = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    proto_field_decoder_if.master bus
);

    localparam logic [2:0] c_ST_KEY    = 3'd0;
    localparam logic [2:0] c_ST_VARINT = 3'd1;
    localparam logic [2:0] c_ST_FIX    = 3'd2;
    localparam logic [2:0] c_ST_LEN    = 3'd3;
    localparam logic [2:0] c_ST_SKIP   = 3'd4;
    localparam logic [2:0] c_ST_EMIT   = 3'd5;
    localparam logic [2:0] c_ST_DRAIN  = 3'd6;

    localparam logic [2:0] c_ERR_OVERFLOW = 3'd1;
    localparam logic [2:0] c_ERR_BAD_WT   = 3'd2;
    localparam logic [2:0] c_ERR_TRUNC    = 3'd3;
    localparam logic [2:0] c_ERR_ZERO_ID  = 3'd4;

    logic [2:0]       r_state;
    logic             r_rdy_en;
    logic [63:0]      r_acc;
    logic [3:0]       r_cnt;
    logic [28:0]      r_key_fid;
    logic [2:0]       r_key_wt;
    logic [LEN_W-1:0] r_len;
    logic             r_skip_next;
    logic [28:0]      r_field_id;
    logic [2:0]       r_wire_type;
    logic [63:0]      r_value;
    logic             r_out_valid;
    logic             r_err;
    logic [2:0]       r_err_code;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_last;
    logic [7:0]  w_d;
    logic [5:0]  w_shift;
    logic [63:0] w_acc_next;
    logic [63:0] w_fix_acc;
    logic        w_fix_done;
    logic        w_len_big;
    logic        w_len_nz;
    logic        w_raise;
    logic [2:0]  w_code;
    logic        w_emit;
    logic [63:0] w_emit_val;

    assign w_d        = bus.in_data;
    assign w_last     = bus.in_last;
    assign w_shift    = 6'(r_cnt) * 6'd7;
    assign w_acc_next = r_acc | ({57'd0, w_d[6:0]} << w_shift);
    assign w_fix_acc  = r_acc | ({56'd0, w_d} << {r_cnt[2:0], 3'b000});
    assign w_fix_done = (r_key_wt == 3'd1) ? (r_cnt == 4'd7) : (r_cnt == 4'd3);
    assign w_len_big  = |(w_acc_next[34:0] >> LEN_W);
    assign w_len_nz   = |w_acc_next[34:0];
    assign w_accept   = bus.in_valid && w_in_ready;

    always_comb begin
        w_in_ready = r_rdy_en && (r_state != c_ST_EMIT);
`ifdef PROTO_LEN_PASSTHRU_EN
        if (r_state == c_ST_SKIP) begin
            w_in_ready = r_rdy_en && bus.pay_ready;
        end
`endif
    end

    // Classify the accepted byte: error, field completion, or plain progress.
    always_comb begin
        w_raise    = 1'b0;
        w_code     = 3'd0;
        w_emit     = 1'b0;
        w_emit_val = w_acc_next;
        if (w_accept) begin
            case (r_state)
                c_ST_KEY: begin
                    if (r_cnt == 4'd4 && (w_d[7] || w_d[6:4] != 3'd0)) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_OVERFLOW;
                    end else if (w_d[7]) begin
                        if (w_last) begin
                            w_raise = 1'b1;
                            w_code  = c_ERR_TRUNC;
                        end
                    end else if (w_acc_next[31:3] == 29'd0) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_ZERO_ID;
                    end else if (w_acc_next[2:0] != 3'd0 && w_acc_next[2:0] != 3'd1 &&
                                 w_acc_next[2:0] != 3'd2 && w_acc_next[2:0] != 3'd5) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_BAD_WT;
                    end else if (w_last) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_TRUNC;
                    end
                end
                c_ST_VARINT: begin
                    if (r_cnt == 4'd9 && w_d > 8'h01) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_OVERFLOW;
                    end else if (w_d[7]) begin
                        if (w_last) begin
                            w_raise = 1'b1;
                            w_code  = c_ERR_TRUNC;
                        end
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                c_ST_FIX: begin
                    if (w_fix_done) begin
                        w_emit     = 1'b1;
                        w_emit_val = w_fix_acc;
                    end else if (w_last) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_TRUNC;
                    end
                end
                c_ST_LEN: begin
                    if (r_cnt == 4'd4 && w_d[7]) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_OVERFLOW;
                    end else if (w_d[7]) begin
                        if (w_last) begin
                            w_raise = 1'b1;
                            w_code  = c_ERR_TRUNC;
                        end
                    end else if (w_len_big) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_OVERFLOW;
                    end else if (w_last && w_len_nz) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_TRUNC;
                    end else begin
                        w_emit = 1'b1;
                    end
                end
                c_ST_SKIP: begin
                    if (w_last && r_len != LEN_W'(1)) begin
                        w_raise = 1'b1;
                        w_code  = c_ERR_TRUNC;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_KEY;
            r_rdy_en    <= 1'b0;
            r_acc       <= 64'd0;
            r_cnt       <= 4'd0;
            r_key_fid   <= 29'd0;
            r_key_wt    <= 3'd0;
            r_len       <= '0;
            r_skip_next <= 1'b0;
            r_field_id  <= 29'd0;
            r_wire_type <= 3'd0;
            r_value     <= 64'd0;
            r_out_valid <= 1'b0;
            r_err       <= 1'b0;
            r_err_code  <= 3'd0;
        end else begin
            r_rdy_en <= 1'b1;
            r_err    <= 1'b0;
            if (w_raise) begin
                r_err      <= 1'b1;
                r_err_code <= w_code;
                r_acc      <= 64'd0;
                r_cnt      <= 4'd0;
                r_state    <= w_last ? c_ST_KEY : c_ST_DRAIN;
            end else if (w_emit) begin
                r_out_valid <= 1'b1;
                r_field_id  <= r_key_fid;
                r_wire_type <= r_key_wt;
                r_value     <= w_emit_val;
                r_acc       <= 64'd0;
                r_cnt       <= 4'd0;
                r_state     <= c_ST_EMIT;
                if (r_state == c_ST_LEN) begin
                    r_len       <= w_acc_next[LEN_W-1:0];
                    r_skip_next <= w_len_nz;
                end else begin
                    r_skip_next <= 1'b0;
                end
            end else if (r_state == c_ST_EMIT) begin
                if (bus.out_ready) begin
                    r_out_valid <= 1'b0;
                    r_state     <= r_skip_next ? c_ST_SKIP : c_ST_KEY;
                end
            end else if (w_accept) begin
                case (r_state)
                    c_ST_KEY: begin
                        if (w_d[7]) begin
                            r_acc <= w_acc_next;
                            r_cnt <= r_cnt + 4'd1;
                        end else begin
                            r_key_fid <= w_acc_next[31:3];
                            r_key_wt  <= w_acc_next[2:0];
                            r_acc     <= 64'd0;
                            r_cnt     <= 4'd0;
                            case (w_acc_next[2:0])
                                3'd0:    r_state <= c_ST_VARINT;
                                3'd2:    r_state <= c_ST_LEN;
                                default: r_state <= c_ST_FIX;
                            endcase
                        end
                    end
                    // only continuation bytes reach here; final bytes emit or raise
                    c_ST_VARINT, c_ST_LEN: begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + 4'd1;
                    end
                    c_ST_FIX: begin
                        r_acc <= w_fix_acc;
                        r_cnt <= r_cnt + 4'd1;
                    end
                    c_ST_SKIP: begin
                        r_len <= r_len - LEN_W'(1);
                        if (r_len == LEN_W'(1)) begin
                            r_state <= c_ST_KEY;
                        end
                    end
                    c_ST_DRAIN: begin
                        if (w_last) begin
                            r_state <= c_ST_KEY;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.out_field_id  = r_field_id;
    assign bus.out_wire_type = r_wire_type;
    assign bus.out_value     = r_value;
    assign bus.out_valid     = r_out_valid;
    assign bus.err           = r_err;
    assign bus.err_code      = r_err_code;

`ifdef PROTO_LEN_PASSTHRU_EN
    assign bus.pay_data  = (r_state == c_ST_SKIP) ? w_d : 8'h00;
    assign bus.pay_valid = (r_state == c_ST_SKIP) && bus.in_valid;
    assign bus.pay_last  = (r_state == c_ST_SKIP) && (r_len == LEN_W'(1));
`else
    logic w_unused_pay_ready;
    assign w_unused_pay_ready = bus.pay_ready;
    assign bus.pay_data  = 8'h00;
    assign bus.pay_valid = 1'b0;
    assign bus.pay_last  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_proto_field_decoder.sv
`default_nettype none
//==============================================================================
// Module   : tb_proto_field_decoder
// Brief    : Self-checking bench; fields are encoded here and must decode back.
// Revision : 1.0
//==============================================================================
module tb_proto_field_decoder;

    typedef struct packed {
        logic [28:0] fid;
        logic [2:0]  wt;
        logic [63:0] val;
    } rec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    proto_field_decoder_if bus ();

    proto_field_decoder #(.LEN_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    rec_t       exp_rec[$];
    rec_t       obs_rec[$];
    logic [2:0] exp_err[$];
    logic [2:0] obs_err[$];
    logic [8:0] exp_pay[$];
    logic [8:0] obs_pay[$];
    logic [7:0] msg[$];
    int total = 0;
    int bad = 0;
    int pay_seen = 0;
    int bp_mode = 0;
    int gap_pct = 0;

    // downstream ready generator: 0 always ready, 1 random, 2 records stalled
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            1: begin
                bus.out_ready = ($urandom % 4) != 0;
                bus.pay_ready = ($urandom % 3) != 0;
            end
            2: begin
                bus.out_ready = 1'b0;
                bus.pay_ready = 1'b1;
            end
            default: begin
                bus.out_ready = 1'b1;
                bus.pay_ready = 1'b1;
            end
        endcase
    end

    always @(negedge clk) begin
        rec_t r;
        if (rst === 1'b0) begin
            if (bus.out_valid && bus.out_ready) begin
                r.fid = bus.out_field_id;
                r.wt  = bus.out_wire_type;
                r.val = bus.out_value;
                obs_rec.push_back(r);
            end
            if (bus.err) obs_err.push_back(bus.err_code);
            if (bus.pay_valid) begin
                pay_seen++;
                if (bus.pay_ready) obs_pay.push_back({bus.pay_last, bus.pay_data});
            end
        end
    end

    function automatic void put_varint(input logic [63:0] v);
        logic [63:0] x;
        x = v;
        do begin
            msg.push_back({(x > 64'd127) ? 1'b1 : 1'b0, x[6:0]});
            x = x >> 7;
        end while (x != 64'd0);
    endfunction

    function automatic void put_field(input logic [28:0] fid, input logic [2:0] wt, input logic [63:0] val);
        rec_t r;
        logic [7:0] b;
        put_varint({32'd0, fid, wt});
        r.fid = fid;
        r.wt  = wt;
        r.val = val;
        case (wt)
            3'd0: put_varint(val);
            3'd1: for (int k = 0; k < 8; k++) msg.push_back(val[8*k +: 8]);
            3'd5: begin
                for (int k = 0; k < 4; k++) msg.push_back(val[8*k +: 8]);
                r.val = {32'd0, val[31:0]};
            end
            default: begin
                put_varint(val);
                for (int k = 0; k < int'(val); k++) begin
                    b = 8'($urandom);
                    msg.push_back(b);
                    exp_pay.push_back({(k == int'(val) - 1) ? 1'b1 : 1'b0, b});
                end
            end
        endcase
        exp_rec.push_back(r);
    endfunction

    task automatic send_msg();
        logic a;
        int n;
        for (int i = 0; i < msg.size(); i++) begin
            while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_data  = msg[i];
            bus.in_valid = 1'b1;
            bus.in_last  = (i == msg.size() - 1);
            n = 0;
            forever begin
                @(negedge clk);
                a = bus.in_ready;
                @(posedge clk); #1;
                if (a) break;
                n++;
                if (n > 500) begin
                    total++; bad++;
                    $display("FAIL send_timeout byte=%0d in_ready got=0 want=1", i);
                    break;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        msg.delete();
    endtask

    task automatic clear_all();
        exp_rec.delete(); obs_rec.delete();
        exp_err.delete(); obs_err.delete();
        exp_pay.delete(); obs_pay.delete();
        pay_seen = 0;
    endtask

    task automatic drain();
        int t = 0;
        while ((obs_rec.size() < exp_rec.size() || obs_err.size() < exp_err.size()) && t < 400) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", bus.in_ready); end
        total++;
        if ({bus.out_valid, bus.err, bus.pay_valid, bus.pay_last} !== 4'b0) begin
            bad++; $display("FAIL reset_flags got=%b want=0000", {bus.out_valid, bus.err, bus.pay_valid, bus.pay_last});
        end
        total++;
        if ({bus.out_field_id, bus.out_wire_type, bus.out_value, bus.err_code} !== 99'd0) begin
            bad++; $display("FAIL reset_outputs fid=%0d wt=%0d val=%h code=%0d want all 0",
                            bus.out_field_id, bus.out_wire_type, bus.out_value, bus.err_code);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_varint();
        clear_all();
        msg = '{8'h08, 8'h96, 8'h01};
        exp_rec.push_back('{fid: 29'd1, wt: 3'd0, val: 64'd150});
        send_msg();
        put_field(29'h1FFFFFFF, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        put_field(29'd5, 3'd0, 64'd0);
        put_field(29'd16, 3'd0, 64'h8000_0000_0000_0000);
        send_msg();
        drain();
        total++;
        if (obs_rec.size() != exp_rec.size()) begin bad++; $display("FAIL varint_count got=%0d want=%0d", obs_rec.size(), exp_rec.size()); end
        for (int i = 0; i < exp_rec.size() && i < obs_rec.size(); i++) begin
            total++;
            if (obs_rec[i] !== exp_rec[i]) begin
                bad++; $display("FAIL varint_rec%0d got fid=%0d wt=%0d val=%h want fid=%0d wt=%0d val=%h", i,
                                obs_rec[i].fid, obs_rec[i].wt, obs_rec[i].val, exp_rec[i].fid, exp_rec[i].wt, exp_rec[i].val);
            end
        end
        total++;
        if (obs_err.size() != 0) begin bad++; $display("FAIL varint_err got=%0d errors want=0", obs_err.size()); end
    endtask

    task automatic test_fixed();
        clear_all();
        msg = '{8'h15, 8'h01, 8'h02, 8'h03, 8'h04};
        exp_rec.push_back('{fid: 29'd2, wt: 3'd5, val: 64'h0403_0201});
        send_msg();
        msg = '{8'h09, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        exp_rec.push_back('{fid: 29'd1, wt: 3'd1, val: 64'h1122_3344_5566_7788});
        send_msg();
        drain();
        total++;
        if (obs_rec.size() != exp_rec.size()) begin bad++; $display("FAIL fixed_count got=%0d want=%0d", obs_rec.size(), exp_rec.size()); end
        for (int i = 0; i < exp_rec.size() && i < obs_rec.size(); i++) begin
            total++;
            if (obs_rec[i] !== exp_rec[i]) begin
                bad++; $display("FAIL fixed_rec%0d got fid=%0d wt=%0d val=%h want fid=%0d wt=%0d val=%h", i,
                                obs_rec[i].fid, obs_rec[i].wt, obs_rec[i].val, exp_rec[i].fid, exp_rec[i].wt, exp_rec[i].val);
            end
        end
    endtask

    task automatic test_len();
        clear_all();
        msg = '{8'h1A, 8'h03, 8'h61, 8'h62, 8'h63};
        exp_rec.push_back('{fid: 29'd3, wt: 3'd2, val: 64'd3});
        exp_pay = '{9'h061, 9'h062, 9'h163};
        send_msg();
        msg = '{8'h08, 8'h05};
        exp_rec.push_back('{fid: 29'd1, wt: 3'd0, val: 64'd5});
        send_msg();
        drain();
        total++;
        if (obs_rec.size() != exp_rec.size()) begin bad++; $display("FAIL len_count got=%0d want=%0d", obs_rec.size(), exp_rec.size()); end
        for (int i = 0; i < exp_rec.size() && i < obs_rec.size(); i++) begin
            total++;
            if (obs_rec[i] !== exp_rec[i]) begin
                bad++; $display("FAIL len_rec%0d got fid=%0d wt=%0d val=%h want fid=%0d wt=%0d val=%h", i,
                                obs_rec[i].fid, obs_rec[i].wt, obs_rec[i].val, exp_rec[i].fid, exp_rec[i].wt, exp_rec[i].val);
            end
        end
`ifdef PROTO_LEN_PASSTHRU_EN
        total++;
        if (obs_pay != exp_pay) begin bad++; $display("FAIL len_payload got=%p want=%p", obs_pay, exp_pay); end
`else
        total++;
        if (pay_seen != 0) begin bad++; $display("FAIL len_no_payload got=%0d pay cycles want=0", pay_seen); end
`endif
    endtask

    task automatic test_errors();
        clear_all();
        msg.push_back(8'h08);
        for (int i = 0; i < 9; i++) msg.push_back(8'hFF);
        msg.push_back(8'h02); msg.push_back(8'hAA); msg.push_back(8'hBB); msg.push_back(8'hCC);
        send_msg();
        msg = '{8'h08, 8'h05};                           send_msg();
        msg = '{8'h08, 8'h96};                           send_msg();
        msg = '{8'h0B, 8'h55, 8'h66};                    send_msg();
        msg = '{8'h00};                                  send_msg();
        msg = '{8'h0A, 8'h80, 8'h80, 8'h80, 8'h80, 8'h10}; send_msg();
        msg = '{8'h0A, 8'h05, 8'h61, 8'h62};             send_msg();
        msg = '{8'h08, 8'h05};                           send_msg();
        exp_err = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd1, 3'd3};
        exp_rec.push_back('{fid: 29'd1, wt: 3'd0, val: 64'd5});
        exp_rec.push_back('{fid: 29'd1, wt: 3'd2, val: 64'd5});
        exp_rec.push_back('{fid: 29'd1, wt: 3'd0, val: 64'd5});
        drain();
        total++;
        if (obs_err.size() != exp_err.size()) begin bad++; $display("FAIL err_count got=%0d want=%0d", obs_err.size(), exp_err.size()); end
        for (int i = 0; i < exp_err.size() && i < obs_err.size(); i++) begin
            total++;
            if (obs_err[i] !== exp_err[i]) begin bad++; $display("FAIL err_code%0d got=%0d want=%0d", i, obs_err[i], exp_err[i]); end
        end
        total++;
        if (obs_rec.size() != exp_rec.size()) begin bad++; $display("FAIL err_rec_count got=%0d want=%0d", obs_rec.size(), exp_rec.size()); end
        for (int i = 0; i < exp_rec.size() && i < obs_rec.size(); i++) begin
            total++;
            if (obs_rec[i] !== exp_rec[i]) begin
                bad++; $display("FAIL err_rec%0d got fid=%0d wt=%0d val=%h want fid=%0d wt=%0d val=%h", i,
                                obs_rec[i].fid, obs_rec[i].wt, obs_rec[i].val, exp_rec[i].fid, exp_rec[i].wt, exp_rec[i].val);
            end
        end
    endtask

    task automatic test_backpressure();
        clear_all();
        bp_mode = 2;
        @(posedge clk); #1;
        msg = '{8'h08, 8'h07, 8'h10, 8'h09};
        exp_rec.push_back('{fid: 29'd1, wt: 3'd0, val: 64'd7});
        exp_rec.push_back('{fid: 29'd2, wt: 3'd0, val: 64'd9});
        fork
            send_msg();
            begin
                int n;
                logic ok;
                logic [95:0] snap;
                n = 0;
                ok = 1'b1;
                while (bus.out_valid !== 1'b1 && n < 200) begin @(negedge clk); n++; end
                snap = {bus.out_field_id, bus.out_wire_type, bus.out_value};
                repeat (5) begin
                    @(negedge clk);
                    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                        {bus.out_field_id, bus.out_wire_type, bus.out_value} !== snap) ok = 1'b0;
                end
                total++;
                if (snap !== {29'd1, 3'd0, 64'd7}) begin bad++; $display("FAIL stall_record got=%h want=%h", snap, {29'd1, 3'd0, 64'd7}); end
                total++;
                if (!ok) begin bad++; $display("FAIL stall_stable got=changed want=stable with in_ready=0"); end
                bp_mode = 0;
            end
        join
        drain();
        total++;
        if (obs_rec.size() != exp_rec.size()) begin bad++; $display("FAIL stall_count got=%0d want=%0d", obs_rec.size(), exp_rec.size()); end
        for (int i = 0; i < exp_rec.size() && i < obs_rec.size(); i++) begin
            total++;
            if (obs_rec[i] !== exp_rec[i]) begin
                bad++; $display("FAIL stall_rec%0d got fid=%0d val=%h want fid=%0d val=%h", i,
                                obs_rec[i].fid, obs_rec[i].val, exp_rec[i].fid, exp_rec[i].val);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        msg = '{8'h08, 8'h01, 8'h10, 8'h02};
        exp_rec.push_back('{fid: 29'd1, wt: 3'd0, val: 64'd1});
        exp_rec.push_back('{fid: 29'd2, wt: 3'd0, val: 64'd2});
        send_msg();
        drain();
        total++;
        if (obs_rec.size() != exp_rec.size()) begin bad++; $display("FAIL b2b_count got=%0d want=%0d", obs_rec.size(), exp_rec.size()); end
        for (int i = 0; i < exp_rec.size() && i < obs_rec.size(); i++) begin
            total++;
            if (obs_rec[i] !== exp_rec[i]) begin
                bad++; $display("FAIL b2b_rec%0d got fid=%0d val=%h want fid=%0d val=%h", i,
                                obs_rec[i].fid, obs_rec[i].val, exp_rec[i].fid, exp_rec[i].val);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  wts [4] = '{3'd0, 3'd1, 3'd2, 3'd5};
        logic [28:0] fid;
        logic [2:0]  wt;
        logic [63:0] val;
        clear_all();
        bp_mode = 1;
        gap_pct = 20;
        for (int m = 0; m < 40; m++) begin
            for (int f = 0; f < int'($urandom_range(4, 1)); f++) begin
                fid = ($urandom % 2) ? 29'($urandom_range(15, 1)) : 29'($urandom);
                if (fid == 29'd0) fid = 29'd1;
                wt = wts[$urandom_range(3, 0)];
                if (wt == 3'd2) val = 64'($urandom_range(6, 0));
                else            val = {$urandom, $urandom} >> $urandom_range(63, 0);
                put_field(fid, wt, val);
            end
            send_msg();
        end
        drain();
        bp_mode = 0;
        gap_pct = 0;
        total++;
        if (obs_rec.size() != exp_rec.size()) begin bad++; $display("FAIL rand_count got=%0d want=%0d", obs_rec.size(), exp_rec.size()); end
        for (int i = 0; i < exp_rec.size() && i < obs_rec.size(); i++) begin
            total++;
            if (obs_rec[i] !== exp_rec[i]) begin
                bad++; $display("FAIL rand_rec%0d got fid=%0d wt=%0d val=%h want fid=%0d wt=%0d val=%h", i,
                                obs_rec[i].fid, obs_rec[i].wt, obs_rec[i].val, exp_rec[i].fid, exp_rec[i].wt, exp_rec[i].val);
            end
        end
        total++;
        if (obs_err.size() != 0) begin bad++; $display("FAIL rand_err got=%0d errors want=0", obs_err.size()); end
`ifdef PROTO_LEN_PASSTHRU_EN
        total++;
        if (obs_pay != exp_pay) begin bad++; $display("FAIL rand_payload got=%0d bytes want=%0d", obs_pay.size(), exp_pay.size()); end
`else
        total++;
        if (pay_seen != 0) begin bad++; $display("FAIL rand_no_payload got=%0d want=0", pay_seen); end
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_varint();
        test_fixed();
        test_len();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
